// File: rtl/intra_pred_rows_pkg.sv
// intra_pred_pkg: mode and FSM state encodings plus the TM clip helper shared by the intra_pred_rows slice
package intra_pred_pkg;
  typedef enum logic [1:0] {MODE_DC, MODE_TM, MODE_VE, MODE_HE} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT} state_e;
  function automatic int clip(input int v, input int hi);
    return v < 0 ? 0 : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/intra_pred_rows_if.sv
// intra_pred_rows_if: start request (mode, neighbours, avail bits) and row stream; master drives requests, slave is the predictor
interface intra_pred_rows_if #(parameter int BIT_WIDTH = 8, parameter int BLOCK_SIZE = 16);
  localparam int IW = $clog2(BLOCK_SIZE);
  logic start_valid;
  logic start_ready;
  logic [1:0] mode;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] top;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] left;
  logic [BIT_WIDTH-1:0] top_left;
  logic top_avail;
  logic left_avail;
  logic row_valid;
  logic row_ready;
  logic [BIT_WIDTH*BLOCK_SIZE-1:0] row_data;
  logic [IW-1:0] row_idx;
  logic row_last;
  modport master (output start_valid, mode, top, left, top_left, top_avail, left_avail, row_ready,
                  input start_ready, row_valid, row_data, row_idx, row_last);
  modport slave (input start_valid, mode, top, left, top_left, top_avail, left_avail, row_ready,
                 output start_ready, row_valid, row_data, row_idx, row_last);
endinterface

// File: rtl/intra_pred_rows_dc_sum.sv
// intra_dc_sum: combinational DC predictor (i_top/i_left edges, i_*_avail select the rounding form, o_dc result)
module intra_dc_sum import intra_pred_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int BLOCK_SIZE = 16
) (
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] i_top,
  input  logic [BIT_WIDTH*BLOCK_SIZE-1:0] i_left,
  input  logic                            i_top_avail,
  input  logic                            i_left_avail,
  output logic [BIT_WIDTH-1:0]            o_dc
);
  localparam int L = $clog2(BLOCK_SIZE);
  localparam int SW = BIT_WIDTH + L + 1;
  logic [SW-1:0] w_st, w_sl;
  always_comb begin
    w_st = '0;
    w_sl = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      w_st = w_st + SW'(i_top[i*BIT_WIDTH +: BIT_WIDTH]);
      w_sl = w_sl + SW'(i_left[i*BIT_WIDTH +: BIT_WIDTH]);
    end
  end
  assign o_dc = i_top_avail && i_left_avail ? BIT_WIDTH'((w_st + w_sl + SW'(BLOCK_SIZE)) >> (L + 1)) :
                i_top_avail                 ? BIT_WIDTH'((w_st + SW'(BLOCK_SIZE / 2)) >> L) :
                i_left_avail                ? BIT_WIDTH'((w_sl + SW'(BLOCK_SIZE / 2)) >> L) :
                                              BIT_WIDTH'(1 << (BIT_WIDTH - 1));
endmodule

// File: rtl/intra_pred_rows.sv
// intra_pred_rows: latches neighbours on start handshake, then streams a DC/TM/VE/HE block one row per beat (clk, rst, bus slave)
module intra_pred_rows import intra_pred_pkg::*; #(
  parameter int BIT_WIDTH = 8,
  parameter int BLOCK_SIZE = 16
) (
  input  logic clk,
  input  logic rst,
  intra_pred_rows_if.slave bus
);
  localparam int IW = $clog2(BLOCK_SIZE);
  localparam int W = BIT_WIDTH * BLOCK_SIZE;
  state_e r_state;
  mode_e r_mode;
  logic [W-1:0] r_top, r_left, r_row_data, w_row;
  logic [BIT_WIDTH-1:0] r_tl, r_dc, w_dc, w_dcv, w_lj, w_ti;
  logic r_ta, r_la, r_start_ready, r_row_valid, r_row_last;
  logic [IW-1:0] r_row_idx, w_nidx;
  logic signed [BIT_WIDTH+1:0] w_tm;
  intra_dc_sum #(.BIT_WIDTH(BIT_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_dc (
    .i_top(r_top), .i_left(r_left), .i_top_avail(r_ta), .i_left_avail(r_la), .o_dc(w_dc)
  );
  assign bus.start_ready = r_start_ready;
  assign bus.row_valid = r_row_valid;
  assign bus.row_data = r_row_data;
  assign bus.row_idx = r_row_idx;
  assign bus.row_last = r_row_last;
  // row 0 is built during CALC, before r_dc holds the fresh DC value
  assign w_nidx = r_state == S_CALC ? '0 : r_row_idx + 1'b1;
  assign w_dcv = r_state == S_CALC ? w_dc : r_dc;
  assign w_lj = r_left[int'(w_nidx)*BIT_WIDTH +: BIT_WIDTH];
  always_comb begin
    w_row = '0;
    w_ti = '0;
    w_tm = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      w_ti = r_top[i*BIT_WIDTH +: BIT_WIDTH];
      w_tm = $signed({2'b00, w_lj}) + $signed({2'b00, w_ti}) - $signed({2'b00, r_tl});
      w_row[i*BIT_WIDTH +: BIT_WIDTH] = r_mode == MODE_DC ? w_dcv :
                                        r_mode == MODE_VE ? w_ti :
                                        r_mode == MODE_HE ? w_lj :
                                        BIT_WIDTH'(clip(int'(w_tm), (1 << BIT_WIDTH) - 1));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_start_ready <= 1'b1;
      r_row_valid <= 1'b0;
      r_row_last <= 1'b0;
      r_row_idx <= '0;
      r_row_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start_valid && r_start_ready) begin
          r_mode <= mode_e'(bus.mode);
          r_top <= bus.top;
          r_left <= bus.left;
          r_tl <= bus.top_left;
          r_ta <= bus.top_avail;
          r_la <= bus.left_avail;
          r_start_ready <= 1'b0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_dc <= w_dc;
          r_row_data <= w_row;
          r_row_idx <= '0;
          r_row_last <= 1'b0;
          r_row_valid <= 1'b1;
          r_state <= S_EMIT;
        end
        S_EMIT: if (bus.row_ready) begin
          if (r_row_last) begin
            r_row_valid <= 1'b0;
            r_row_last <= 1'b0;
            r_start_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_row_idx <= w_nidx;
            r_row_data <= w_row;
            r_row_last <= w_nidx == IW'(BLOCK_SIZE - 1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_intra_pred_rows.sv
// tb_intra_pred_rows: drives a 16-wide and a 4-wide predictor through directed and random blocks against an arithmetic model
module tb_intra_pred_rows;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic sel = 1'b0, sv = 1'b0, rr = 1'b1, ta = 1'b0, la = 1'b0;
  logic [1:0] mode_v = '0;
  logic [7:0] tl_v = '0;
  logic [127:0] top_v = '0, left_v = '0;
  int tv[16], lv[16], m_tv[16], m_lv[16];
  int m_mode, m_tl, bs = 16;
  bit m_ta, m_la;
  int n_vec = 0, n_err = 0;
  intra_pred_rows_if #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) if16();
  intra_pred_rows_if #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) if4();
  intra_pred_rows #(.BIT_WIDTH(8), .BLOCK_SIZE(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  intra_pred_rows #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  assign if16.start_valid = sv & ~sel;
  assign if4.start_valid = sv & sel;
  assign if16.mode = mode_v;
  assign if4.mode = mode_v;
  assign if16.top = top_v;
  assign if4.top = top_v[31:0];
  assign if16.left = left_v;
  assign if4.left = left_v[31:0];
  assign if16.top_left = tl_v;
  assign if4.top_left = tl_v;
  assign if16.top_avail = ta;
  assign if4.top_avail = ta;
  assign if16.left_avail = la;
  assign if4.left_avail = la;
  assign if16.row_ready = rr;
  assign if4.row_ready = rr;
  logic o_sr, o_rv, o_last;
  logic [127:0] o_data;
  logic [3:0] o_idx;
  assign o_sr = sel ? if4.start_ready : if16.start_ready;
  assign o_rv = sel ? if4.row_valid : if16.row_valid;
  assign o_last = sel ? if4.row_last : if16.row_last;
  assign o_data = sel ? {96'b0, if4.row_data} : if16.row_data;
  assign o_idx = sel ? {2'b00, if4.row_idx} : if16.row_idx;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sample(int j, int i);
    int st = 0, sl = 0, v;
    for (int k = 0; k < bs; k++) begin
      st += m_tv[k];
      sl += m_lv[k];
    end
    case (m_mode)
      0: return m_ta && m_la ? (st + sl + bs) / (2 * bs) : m_ta ? (st + bs / 2) / bs : m_la ? (sl + bs / 2) / bs : 128;
      1: begin
        v = m_lv[j] + m_tv[i] - m_tl;
        return v < 0 ? 0 : v > 255 ? 255 : v;
      end
      2: return m_tv[i];
      default: return m_lv[j];
    endcase
  endfunction

  function automatic logic [127:0] exp_row(int j);
    logic [127:0] r = '0;
    for (int i = 0; i < bs; i++) r[i*8 +: 8] = 8'(exp_sample(j, i));
    return r;
  endfunction

  task automatic drive_vec();
    for (int i = 0; i < 16; i++) begin
      top_v[i*8 +: 8] = 8'(tv[i]);
      left_v[i*8 +: 8] = 8'(lv[i]);
    end
  endtask

  task automatic rand_edges();
    for (int i = 0; i < 16; i++) begin
      tv[i] = int'($urandom_range(255));
      lv[i] = int'($urandom_range(255));
    end
  endtask

  task automatic run_block(input logic [1:0] md, input bit a_t, input bit a_l, input int tl,
                           input int pstall, input bit hold, input int abort_row);
    int r = 0, edges = 0, guard = 0;
    bit hs;
    mode_v = md;
    ta = a_t;
    la = a_l;
    tl_v = 8'(tl);
    drive_vec();
    sv = 1'b1;
    chk("start_ready_idle", o_sr, 1);
    m_mode = int'(md);
    m_ta = a_t;
    m_la = a_l;
    m_tl = tl;
    m_tv = tv;
    m_lv = lv;
    @(posedge clk);
    @(negedge clk);
    sv = hold;
    rand_edges();
    drive_vec();
    tl_v = 8'($urandom_range(255));
    mode_v = 2'($urandom_range(3));
    ta = 1'($urandom_range(1));
    la = 1'($urandom_range(1));
    chk("calc_valid", o_rv, 0);
    chk("calc_ready", o_sr, 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    while (r < bs) begin
      if (guard++ > 400) begin
        n_vec++;
        n_err++;
        $error("FAIL timeout: observed %0d rows expected %0d", r, bs);
        break;
      end
      rr = $urandom_range(99) >= pstall;
      chk("row_valid", o_rv, 1);
      chk("row_idx", o_idx, r);
      chk("row_last", o_last, r == bs - 1);
      chk("row_data", o_data, exp_row(r));
      chk("busy_ready", o_sr, 0);
      if (r == abort_row) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sv = 1'b0;
        rr = 1'b1;
        chk("rst_valid", o_rv, 0);
        chk("rst_ready", o_sr, 1);
        chk("rst_last", o_last, 0);
        return;
      end
      hs = rr;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (hs) r++;
    end
    sv = 1'b0;
    rr = 1'b1;
    chk("done_valid", o_rv, 0);
    chk("done_ready", o_sr, 1);
    if (pstall == 0) chk("latency", edges, bs + 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", o_rv, 0);
    chk("reset_last", o_last, 0);
    chk("reset_idx", o_idx, 0);
    chk("reset_data", o_data, 0);
    chk("reset_ready", o_sr, 1);
    rst = 1'b0;
    rand_edges();
    for (int i = 0; i < 16; i++) tv[i] = i;
    run_block(2'd2, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    for (int j = 0; j < 16; j++) lv[j] = 16 + j;
    run_block(2'd3, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) begin
      tv[i] = 16;
      lv[i] = 32;
    end
    run_block(2'd0, 1'b1, 1'b1, 0, 0, 1'b0, -1);
    run_block(2'd0, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    run_block(2'd0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) begin
      tv[i] = 240;
      lv[i] = 32;
    end
    run_block(2'd1, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    for (int i = 0; i < 16; i++) begin
      tv[i] = 5;
      lv[i] = 0;
    end
    run_block(2'd1, 1'b0, 1'b0, 64, 0, 1'b0, -1);
    repeat (8) begin
      rand_edges();
      run_block(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                int'($urandom_range(255)), 40, 1'($urandom_range(1)), -1);
    end
    rand_edges();
    run_block(2'd2, 1'b0, 1'b0, 0, 0, 1'b1, 7);
    rand_edges();
    run_block(2'd2, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    sel = 1'b1;
    bs = 4;
    rand_edges();
    run_block(2'd0, 1'b1, 1'b1, 0, 0, 1'b0, -1);
    for (int m = 0; m < 4; m++) begin
      rand_edges();
      run_block(2'(m), 1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(255)), 30, 1'b1, -1);
    end
    rand_edges();
    run_block(2'd2, 1'b0, 1'b0, 0, 0, 1'b0, 2);
    rand_edges();
    run_block(2'd2, 1'b0, 1'b0, 0, 0, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/intra_pred_rows.md
Name: intra_pred_rows

Overview:
Parametrised successor to the combinational vertical predictor. Generates one intra-prediction block for a selectable mode: DC, TrueMotion (TM), Vertical (VE) or Horizontal (HE). Neighbour samples are latched on a start handshake, and the block is streamed out one row per beat under valid/ready. It sits between the neighbour-sample fetch stage and the residual/SAD stage of the encoder's intra mode-decision loop.

Parameters:
BIT_WIDTH, 8, bits per sample.
BLOCK_SIZE, 16, block edge in samples; must be a power of two, 4..16.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
start_valid  in  1  request present.
start_ready  out  1  block can accept a request (IDLE only).
mode  in  2  0=DC, 1=TM, 2=VE, 3=HE.
top  in  BIT_WIDTH*BLOCK_SIZE  row above; sample i at [i*BIT_WIDTH +: BIT_WIDTH].
left  in  BIT_WIDTH*BLOCK_SIZE  column to the left; sample j at [j*BIT_WIDTH +: BIT_WIDTH].
top_left  in  BIT_WIDTH  corner sample.
top_avail  in  1  top edge valid (DC only).
left_avail  in  1  left edge valid (DC only).
row_valid  out  1  row_data holds a valid row.
row_ready  in  1  consumer accepts the row.
row_data  out  BIT_WIDTH*BLOCK_SIZE  predicted row; same packing as top.
row_idx  out  clog2(BLOCK_SIZE)  index of the current row, 0..BLOCK_SIZE-1.
row_last  out  1  asserted with row_idx == BLOCK_SIZE-1.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, row_valid=0, row_last=0, row_idx=0, row_data=0, start_ready=1 the following cycle. Reset takes effect mid-block; the in-flight block is dropped with no further rows.
- FSM states and transitions:
  - IDLE: start_ready=1. On start_valid&&start_ready, latch mode, top, left, top_left, top_avail and left_avail; go to CALC. Inputs are ignored outside this acceptance cycle.
  - CALC: one cycle. Computes and registers the DC value; all modes pass through CALC for uniform latency. Go to EMIT with row_idx=0.
  - EMIT: row_valid=1. On row_valid&&row_ready: if row_idx==BLOCK_SIZE-1, go to IDLE (row_valid=0 next cycle); otherwise row_idx+=1.
- Latency and throughput:
  - Accept at edge T; first row valid from T+2; rows advance at most one per cycle.
  - Block occupancy is BLOCK_SIZE+2 cycles minimum. No overlap: start_ready=0 outside IDLE.
- Backpressure: while row_valid&&!row_ready, row_data, row_idx and row_last are held stable.
- Row generation for row j, column i:
  - VE: top[i].
  - HE: left[j].
  - TM: clip(left[j]+top[i]-top_left, 0, 2^BIT_WIDTH-1), computed in BIT_WIDTH+2-bit signed arithmetic.
  - DC: the registered dc value in every column.
- DC value, with L=log2(BLOCK_SIZE):
  - both edges available: (sum(top)+sum(left)+BLOCK_SIZE) >> (L+1).
  - top only: (sum(top)+BLOCK_SIZE/2) >> L.
  - left only: same form over left.
  - neither: 1<<(BIT_WIDTH-1).
  - Sum width is BIT_WIDTH+L+1 bits, so no overflow is possible.
- For TM, VE and HE the upstream stage substitutes unavailable edges; top_avail and left_avail are ignored for those modes.
- start_valid during reset, or outside IDLE, is not accepted and not queued.

Decomposition:
- Shared package intra_pred_pkg:
  - mode encodings MODE_DC, MODE_TM, MODE_VE, MODE_HE;
  - FSM state encodings S_IDLE, S_CALC, S_EMIT;
  - the clip function.
- Sub-module intra_dc_sum: combinational adder tree plus rounding and shift. It takes top, left, the avail bits and BLOCK_SIZE, and outputs dc. Its result is registered in CALC.

Test Plan:
- VE, BLOCK_SIZE=16, top[i]=i, row_ready=1 -> 16 rows from T+2, each row equal to 0x00..0x0F; row_last only on row 15; start_ready returns at T+18.
- HE, left[j]=0x10+j -> row j is all 0x10+j.
- DC cases:
  - top all 0x10, left all 0x20, both avail -> all samples 0x18 ((256+512+16)>>5).
  - neither avail -> all 0x80.
  - top only -> 0x10.
- TM clip: top all 0xF0, left all 0x20, top_left=0x00 -> all 0xFF. Then top all 0x05, left all 0x00, top_left=0x40 -> all 0x00.
- Backpressure: row_ready toggles randomly -> row_data and row_idx stable while stalled; exactly 16 handshakes per block; start_valid held high during EMIT is not accepted.
- Reset mid-EMIT at row 7 -> row_valid=0 next cycle, start_ready=1; a new VE request then yields correct rows from row 0. Repeat at BLOCK_SIZE=4: 4 rows, DC shift L+1=3.
